jam_param: RTL and testbench

- Parametrised exhaustive job-assignment engine: loads an N x N worker/job cost matrix and walks all N! assignments in lexicographic order, one per clock.
- Reports the optimal total cost, the number of assignments reaching it, and the first (lexicographically smallest) optimal assignment.
- Supports a minimise or maximise mode and restart without reset.
- The cost adder is pipelined so the closing timing path is bounded.

---
 rtl/jam_pkg.sv | 35 +++
 rtl/jam_param_if.sv | 39 +++
 rtl/jam_perm_next.sv | 53 +++++
 rtl/jam_param.sv | 177 +++++++++++++++++
 tb/tb_jam_param.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/jam_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | jam_pkg                                                          |
// | Shared types, mode constants and width helpers for jam_param.    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package jam_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CALC  = 3'd2,
    DRAIN = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic MODE_MIN = 1'b0;
  localparam logic MODE_MAX = 1'b1;

  function automatic int jam_fact(input int n);
    int f;
    f = 1;
    for (int i = 2; i <= n; i++) f = f * i;
    return f;
  endfunction

  function automatic int jam_clog2(input int n);
    int w;
    w = 0;
    for (int i = 0; i < 32; i++) if ((1 << w) < n) w = w + 1;
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/jam_param_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | jam_param_if                                                     |
// | Control, cost-fetch and result bundle of the assignment engine.  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
interface jam_param_if #(
  parameter int N      = 8,
  parameter int COST_W = 7,
  parameter int CNT_W  = 16
);
  import jam_pkg::*;

  localparam int IDX_W = jam_clog2(N);
  localparam int SUM_W = COST_W + jam_clog2(N);

  logic                 Start;
  logic                 Mode;
  logic [IDX_W-1:0]     W;
  logic [IDX_W-1:0]     J;
  logic [COST_W-1:0]    Cost;
  logic [SUM_W-1:0]     BestCost;
  logic [CNT_W-1:0]     MatchCount;
  logic [N*IDX_W-1:0]   BestPerm;
  logic                 Busy;
  logic                 Valid;

  modport master (
    output Start, Mode, Cost,
    input  W, J, BestCost, MatchCount, BestPerm, Busy, Valid
  );

  modport slave (
    input  Start, Mode, Cost,
    output W, J, BestCost, MatchCount, BestPerm, Busy, Valid
  );

endinterface
`default_nettype wire

// File: rtl/jam_perm_next.sv
`default_nettype none
// +------------------------------------------------------------------+
// | jam_perm_next                                                    |
// | Combinational lexicographic next-permutation; flags descending.  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module jam_perm_next #(
  parameter int N     = 8,
  parameter int IDX_W = 3
) (
  input  logic [N*IDX_W-1:0] i_perm,
  output logic [N*IDX_W-1:0] o_next,
  output logic               o_is_last
);

  logic [IDX_W-1:0] w_a [N];
  logic [IDX_W-1:0] w_b [N];
  logic [IDX_W-1:0] w_c [N];
  int               w_piv;
  int               w_swp;
  logic             w_found;

  for (genvar k = 0; k < N; k++) begin : g_pack
    assign w_a[k] = i_perm[k*IDX_W +: IDX_W];
    assign o_next[k*IDX_W +: IDX_W] = w_c[k];
  end

  // Position 0 is the most significant digit: pivot is the rightmost ascent.
  always_comb begin
    w_found = 1'b0;
    w_piv   = 0;
    for (int k = 0; k < N-1; k++) begin
      if (w_a[k] < w_a[k+1]) begin
        w_found = 1'b1;
        w_piv   = k;
      end
    end
    w_swp = w_piv;
    for (int k = 0; k < N; k++) begin
      if ((k > w_piv) && (w_a[k] > w_a[w_piv])) w_swp = k;
    end
    for (int k = 0; k < N; k++) w_b[k] = w_a[k];
    w_b[w_piv] = w_a[w_swp];
    w_b[w_swp] = w_a[w_piv];
    for (int k = 0; k < N; k++) begin
      w_c[k] = w_b[k];
      if (w_found && (k > w_piv)) w_c[k] = w_b[N + w_piv - k];
    end
    o_is_last = ~w_found;
  end

endmodule
`default_nettype wire

// File: rtl/jam_param.sv
`default_nettype none
// +------------------------------------------------------------------+
// | jam_param                                                        |
// | Exhaustive N x N job assignment: loads costs, walks all N! perms.|
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module jam_param
  import jam_pkg::*;
#(
  parameter int N      = 8,
  parameter int COST_W = 7,
  parameter int CNT_W  = 16
) (
  input  logic        CLK,
  input  logic        RST,
  jam_param_if.slave  bus
);

  localparam int IDX_W  = jam_clog2(N);
  localparam int SUM_W  = COST_W + jam_clog2(N);
  localparam int NPAIR  = (N + 1) / 2;
  localparam int PSUM_W = COST_W + 1;

  state_t              r_state, w_state_nxt;
  logic                r_mode;
  logic [IDX_W-1:0]    r_w, r_j;
  logic [1:0]          r_drain;
  logic                r_busy, r_valid;
  logic [COST_W-1:0]   r_mat [N][N];
  logic [N*IDX_W-1:0]  r_perm, w_perm_nxt, w_ident;
  logic                w_is_last;
  logic                w_start_ok, w_load_last;

  logic [COST_W-1:0]   w_cost [N];
  logic [PSUM_W-1:0]   w_psum [NPAIR];
  logic [PSUM_W-1:0]   r_psum [NPAIR];
  logic [SUM_W-1:0]    w_total, r_total;
  logic [N*IDX_W-1:0]  r_perm1, r_perm2;
  logic                r_v1, r_v2;
  logic                w_better;

  logic [SUM_W-1:0]    r_best;
  logic [CNT_W-1:0]    r_count;
  logic [N*IDX_W-1:0]  r_best_perm;

  for (genvar k = 0; k < N; k++) begin : g_ident
    assign w_ident[k*IDX_W +: IDX_W] = IDX_W'(k);
  end

  jam_perm_next #(.N(N), .IDX_W(IDX_W)) u_next (
    .i_perm    (r_perm),
    .o_next    (w_perm_nxt),
    .o_is_last (w_is_last)
  );

  assign w_start_ok  = bus.Start && ((r_state == IDLE) || (r_state == DONE));
  assign w_load_last = (r_state == LOAD) && (r_w == IDX_W'(N-1)) && (r_j == IDX_W'(N-1));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE, DONE: if (bus.Start)           w_state_nxt = LOAD;
      LOAD:       if (w_load_last)         w_state_nxt = CALC;
      CALC:       if (w_is_last)           w_state_nxt = DRAIN;
      DRAIN:      if (r_drain == 2'd2)     w_state_nxt = DONE;
      default:                             w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
      r_mode  <= MODE_MIN;
      r_w     <= '0;
      r_j     <= '0;
      r_drain <= '0;
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_perm  <= w_ident;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt == LOAD) || (w_state_nxt == CALC) || (w_state_nxt == DRAIN);
      r_valid <= (w_state_nxt == DONE);
      if (w_start_ok) begin
        r_mode <= bus.Mode;
        r_w    <= '0;
        r_j    <= '0;
      end
      if (r_state == LOAD) begin
        if (r_j == IDX_W'(N-1)) begin
          r_j <= '0;
          r_w <= w_load_last ? '0 : r_w + IDX_W'(1);
        end else begin
          r_j <= r_j + IDX_W'(1);
        end
        if (w_load_last) r_perm <= w_ident;
      end
      if (r_state == CALC) begin
        r_perm  <= w_perm_nxt;
        r_drain <= '0;
      end
      if (r_state == DRAIN) r_drain <= r_drain + 2'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (r_state == LOAD) r_mat[r_w][r_j] <= bus.Cost;
  end

  for (genvar k = 0; k < N; k++) begin : g_cost
    assign w_cost[k] = r_mat[k][r_perm[k*IDX_W +: IDX_W]];
  end

  for (genvar p = 0; p < NPAIR; p++) begin : g_pair
    if (2*p + 1 < N) begin : g_two
      assign w_psum[p] = PSUM_W'(w_cost[2*p]) + PSUM_W'(w_cost[2*p+1]);
    end else begin : g_one
      assign w_psum[p] = PSUM_W'(w_cost[2*p]);
    end
  end

  always_comb begin
    w_total = '0;
    for (int p = 0; p < NPAIR; p++) w_total = w_total + SUM_W'(r_psum[p]);
  end

  // Stage 1 holds pairwise sums, stage 2 the full total; the compare
  // acts on the registered total so the adder never shares a path with it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
    end else begin
      r_v1 <= (r_state == CALC);
      r_v2 <= r_v1;
    end
  end

  always_ff @(posedge CLK) begin
    for (int p = 0; p < NPAIR; p++) r_psum[p] <= w_psum[p];
    r_perm1 <= r_perm;
    r_perm2 <= r_perm1;
    r_total <= w_total;
  end

  assign w_better = (r_mode == MODE_MAX) ? (r_total > r_best) : (r_total < r_best);

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_best      <= '0;
      r_count     <= '0;
      r_best_perm <= w_ident;
    end else if (w_start_ok) begin
      r_best      <= (bus.Mode == MODE_MIN) ? {SUM_W{1'b1}} : {SUM_W{1'b0}};
      r_count     <= '0;
      r_best_perm <= w_ident;
    end else if (r_v2) begin
      if (w_better) begin
        r_best      <= r_total;
        r_count     <= CNT_W'(1);
        r_best_perm <= r_perm2;
      end else if ((r_total == r_best) && (r_count != {CNT_W{1'b1}})) begin
        r_count <= r_count + CNT_W'(1);
      end
    end
  end

  assign bus.W          = r_w;
  assign bus.J          = r_j;
  assign bus.BestCost   = r_best;
  assign bus.MatchCount = r_count;
  assign bus.BestPerm   = r_best_perm;
  assign bus.Busy       = r_busy;
  assign bus.Valid      = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_jam_param.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_jam_param                                                     |
// | Random/directed runs on N=8 and N=3 engines vs a Lehmer model.   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_jam_param;
  import jam_pkg::*;

  typedef struct {
    longint best;
    longint cnt;
    longint perm;
    longint vedge;
  } exp_t;

  logic CLK = 1'b0;
  logic rst8 = 1'b1;
  logic rst3 = 1'b1;
  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  int   m8 [8][8];
  int   m3 [8][8];
  exp_t q8 [$];
  exp_t q3 [$];
  bit   pv8 = 1'b0;
  bit   pv3 = 1'b0;
  longint last_best3 = 0;

  jam_param_if #(.N(8), .COST_W(7), .CNT_W(16)) b8 ();
  jam_param_if #(.N(3), .COST_W(7), .CNT_W(16)) b3 ();

  assign b8.Cost = 7'(m8[b8.W][b8.J]);
  assign b3.Cost = 7'(m3[b3.W][b3.J]);

  jam_param #(.N(8), .COST_W(7), .CNT_W(16)) u8 (.CLK(CLK), .RST(rst8), .bus(b8.slave));
  jam_param #(.N(3), .COST_W(7), .CNT_W(16)) u3 (.CLK(CLK), .RST(rst3), .bus(b3.slave));

  task automatic chk(input string nm, input longint act, input longint exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Walks permutations in lexicographic order by decoding the rank r in the
  // factorial number system; the first strictly better total wins ties.
  function automatic exp_t model(input int n, input int mat [8][8], input bit maxm);
    exp_t   e;
    int     nf, idxw, rem, d, f, np, tot, job;
    int     pool [8];
    longint pv;
    bit     first;
    nf = jam_fact(n);
    idxw = jam_clog2(n);
    first = 1'b1;
    e.best = 0; e.cnt = 0; e.perm = 0; e.vedge = 0;
    for (int r = 0; r < nf; r++) begin
      for (int i = 0; i < 8; i++) pool[i] = i;
      np = n; rem = r; tot = 0; pv = 0;
      for (int k = 0; k < n; k++) begin
        f = jam_fact(n - 1 - k);
        d = rem / f;
        rem = rem % f;
        job = pool[d];
        for (int t = d; t < np - 1; t++) pool[t] = pool[t+1];
        np = np - 1;
        tot = tot + mat[k][job];
        pv = pv | (longint'(job) << (k * idxw));
      end
      if (first || (maxm ? (tot > e.best) : (tot < e.best))) begin
        e.best = tot; e.cnt = 1; e.perm = pv; first = 1'b0;
      end else if (tot == e.best) begin
        e.cnt = e.cnt + 1;
      end
    end
    e.vedge = n * n + nf + 3;
    return e;
  endfunction

  function automatic longint ident(input int n);
    longint v;
    v = 0;
    for (int k = 0; k < n; k++) v = v | (longint'(k) << (k * jam_clog2(n)));
    return v;
  endfunction

  task automatic check_reset8(input string nm);
    chk({nm, "_W"},     longint'(b8.W), 0);
    chk({nm, "_J"},     longint'(b8.J), 0);
    chk({nm, "_best"},  longint'(b8.BestCost), 0);
    chk({nm, "_cnt"},   longint'(b8.MatchCount), 0);
    chk({nm, "_perm"},  longint'(b8.BestPerm), ident(8));
    chk({nm, "_busy"},  longint'(b8.Busy), 0);
    chk({nm, "_valid"}, longint'(b8.Valid), 0);
  endtask

  task automatic check_reset3(input string nm);
    chk({nm, "_W"},     longint'(b3.W), 0);
    chk({nm, "_J"},     longint'(b3.J), 0);
    chk({nm, "_best"},  longint'(b3.BestCost), 0);
    chk({nm, "_cnt"},   longint'(b3.MatchCount), 0);
    chk({nm, "_perm"},  longint'(b3.BestPerm), ident(3));
    chk({nm, "_busy"},  longint'(b3.Busy), 0);
    chk({nm, "_valid"}, longint'(b3.Valid), 0);
  endtask

  task automatic start8(input bit mode, input bit expect_done);
    exp_t e;
    @(negedge CLK);
    b8.Start = 1'b1; b8.Mode = mode;
    if (expect_done) begin
      e = model(8, m8, mode);
      e.vedge = e.vedge + cyc + 1;
      q8.push_back(e);
    end
    @(negedge CLK);
    b8.Start = 1'b0;
  endtask

  task automatic start3(input bit mode);
    exp_t e;
    @(negedge CLK);
    b3.Start = 1'b1; b3.Mode = mode;
    e = model(3, m3, mode);
    e.vedge = e.vedge + cyc + 1;
    last_best3 = e.best;
    q3.push_back(e);
    @(negedge CLK);
    b3.Start = 1'b0;
    chk("n3_start_W", longint'(b3.W), 0);
    chk("n3_start_J", longint'(b3.J), 0);
    chk("n3_start_busy", longint'(b3.Busy), 1);
    chk("n3_start_valid", longint'(b3.Valid), 0);
  endtask

  task automatic wait8(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge CLK);
      if (q8.size() == 0) break;
    end
    chk("n8_timeout", longint'(q8.size()), 0);
    q8.delete();
  endtask

  task automatic wait3(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge CLK);
      if (q3.size() == 0) break;
    end
    chk("n3_timeout", longint'(q3.size()), 0);
    q3.delete();
  endtask

  // Monitors: compare on every rising Valid, independently of stimulus.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK); #1;
      if (b8.Valid && !pv8) begin
        if (q8.size() == 0) begin
          chk("n8_unexpected_valid", 1, 0);
        end else begin
          e = q8.pop_front();
          chk("n8_best", longint'(b8.BestCost), e.best);
          chk("n8_cnt", longint'(b8.MatchCount), e.cnt);
          chk("n8_perm", longint'(b8.BestPerm), e.perm);
          chk("n8_valid_edge", longint'(cyc), e.vedge);
          chk("n8_busy_low", longint'(b8.Busy), 0);
        end
      end
      pv8 = b8.Valid;
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(posedge CLK); #1;
      if (b3.Valid && !pv3) begin
        if (q3.size() == 0) begin
          chk("n3_unexpected_valid", 1, 0);
        end else begin
          e = q3.pop_front();
          chk("n3_best", longint'(b3.BestCost), e.best);
          chk("n3_cnt", longint'(b3.MatchCount), e.cnt);
          chk("n3_perm", longint'(b3.BestPerm), e.perm);
          chk("n3_valid_edge", longint'(cyc), e.vedge);
          chk("n3_busy_low", longint'(b3.Busy), 0);
        end
      end
      pv3 = b3.Valid;
    end
  end

  initial begin
    b8.Start = 1'b0; b8.Mode = 1'b0;
    b3.Start = 1'b0; b3.Mode = 1'b0;
    for (int i = 0; i < 8; i++)
      for (int k = 0; k < 8; k++) begin
        m8[i][k] = 0; m3[i][k] = 0;
      end
    fork
      begin : p_n8
        int     dj [8] = '{1, 0, 3, 2, 5, 4, 7, 6};
        longint dperm;
        repeat (3) @(negedge CLK);
        rst8 = 1'b0;
        check_reset8("n8_reset");
        // Abort a run mid-CALC with RST.
        for (int i = 0; i < 8; i++)
          for (int k = 0; k < 8; k++) m8[i][k] = 5;
        start8(1'b0, 1'b0);
        repeat (85) @(negedge CLK);
        chk("n8_busy_calc", longint'(b8.Busy), 1);
        rst8 = 1'b1;
        @(negedge CLK);
        check_reset8("n8_abort");
        rst8 = 1'b0;
        // Diagonal zero, off-diagonal 10, maximise: best is a derangement.
        for (int i = 0; i < 8; i++)
          for (int k = 0; k < 8; k++) m8[i][k] = (i == k) ? 0 : 10;
        start8(1'b1, 1'b1);
        wait8(41000);
        dperm = 0;
        for (int k = 0; k < 8; k++) dperm = dperm | (longint'(dj[k]) << (3 * k));
        chk("n8_derange_best", longint'(b8.BestCost), 80);
        chk("n8_derange_cnt", longint'(b8.MatchCount), 14833);
        chk("n8_derange_perm", longint'(b8.BestPerm), dperm);
      end
      begin : p_n3
        repeat (3) @(negedge CLK);
        rst3 = 1'b0;
        check_reset3("n3_reset");
        for (int i = 0; i < 3; i++)
          for (int k = 0; k < 3; k++) m3[i][k] = (i + 1) * (k + 1);
        start3(1'b0);
        wait3(100);
        chk("n3_prod_best", longint'(b3.BestCost), 10);
        chk("n3_prod_cnt", longint'(b3.MatchCount), 1);
        chk("n3_prod_perm", longint'(b3.BestPerm), 6);
        for (int i = 0; i < 3; i++)
          for (int k = 0; k < 3; k++) m3[i][k] = (i == k) ? 0 : 10;
        start3(1'b0);
        wait3(100);
        chk("n3_diag_best", longint'(b3.BestCost), 0);
        chk("n3_diag_cnt", longint'(b3.MatchCount), 1);
        chk("n3_diag_perm", longint'(b3.BestPerm), ident(3));
        // Start pulsed during CALC must not restart or reload.
        start3(1'b0);
        repeat (10) @(negedge CLK);
        for (int i = 0; i < 3; i++)
          for (int k = 0; k < 3; k++) m3[i][k] = 127;
        b3.Start = 1'b1; b3.Mode = 1'b1;
        @(negedge CLK);
        b3.Start = 1'b0;
        chk("n3_ignore_busy", longint'(b3.Busy), 1);
        chk("n3_ignore_W", longint'(b3.W), 0);
        wait3(100);
        // Randomised runs, restarting from DONE each time.
        for (int it = 0; it < 30; it++) begin
          for (int i = 0; i < 3; i++)
            for (int k = 0; k < 3; k++)
              m3[i][k] = (it % 2 == 0) ? int'($urandom_range(3)) : int'($urandom_range(127));
          start3(1'($urandom_range(1)));
          wait3(100);
          repeat (3) @(negedge CLK);
          chk("n3_hold_valid", longint'(b3.Valid), 1);
          chk("n3_hold_best", longint'(b3.BestCost), last_best3);
        end
        // Abort mid-CALC on the small engine as well.
        start3(1'b1);
        q3.delete();
        repeat (11) @(negedge CLK);
        rst3 = 1'b1;
        @(negedge CLK);
        check_reset3("n3_abort");
        rst3 = 1'b0;
      end
    join
    repeat (4) @(negedge CLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
